// File: rtl/conv_pkg.sv
// Shared constants and state type for the convolution memory read path.
package conv_pkg;
  localparam int IMG_W2      = 8;
  localparam int CONV2_CH    = 3;
  localparam int CONV_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/conv2_mem_read_fifo2.sv
// Two-entry synchronous FIFO; the head entry is presented directly from storage.
module fifo2 #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/conv2_mem_read.sv
// Walks the conv2 output RAM in 2x2 pooling-window order and streams words
// to the pool stage, tolerating arbitrary back-pressure.
module conv2_mem_read
  import conv_pkg::*;
#(
  parameter int DATA_W   = CONV_DATA_W,
  parameter int IMG_W    = IMG_W2,
  parameter int CHANNELS = CONV2_CH,
  localparam int ADDR_W  = $clog2(IMG_W * IMG_W),
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [CH_W-1:0]   ch,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_win_last,
  output logic              out_ch_last,
  output logic              busy,
  output logic              done
);
  localparam int LOG_W = $clog2(IMG_W);
  localparam int WB    = (IMG_W > 2) ? LOG_W - 1 : 1;

  rd_state_t       r_state;
  logic [1:0]      r_e;
  logic [WB-1:0]   r_wc;
  logic [WB-1:0]   r_wr;
  logic [CH_W-1:0] r_ch;
  logic            r_inflight;
  logic            r_tag_win;
  logic            r_tag_ch;
  logic            r_done;

  logic              w_pop;
  logic [1:0]        w_count;
  logic [2:0]        w_occ;
  logic [DATA_W+1:0] w_dout;
  logic              w_last_e;
  logic              w_wc_max;
  logic              w_wr_max;
  logic              w_ch_max;
  logic              w_ch_last;
  logic              w_final;
  logic              w_drained;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;

  assign w_last_e  = (r_e == 2'd3);
  assign w_wc_max  = (r_wc == WB'(IMG_W / 2 - 1));
  assign w_wr_max  = (r_wr == WB'(IMG_W / 2 - 1));
  assign w_ch_max  = (r_ch == CH_W'(CHANNELS - 1));
  assign w_ch_last = w_last_e && w_wc_max && w_wr_max;
  assign w_final   = w_ch_last && w_ch_max;

  // Row = {wr, dy}, col = {wc, dx}; IMG_W is a power of two so this is a concat.
  assign w_row = ADDR_W'({r_wr, r_e[1]});
  assign w_col = ADDR_W'({r_wc, r_e[0]});
  assign addr  = (w_row << LOG_W) | w_col;
  assign ch    = r_ch;

  assign out_valid = (w_count != 2'd0);
  assign w_pop     = out_valid && out_ready;

  // Words already owed to the FIFO after this edge; a new read needs a free slot.
  assign w_occ     = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign rd_en     = (r_state == RUN) && (w_occ < 3'd2);
  assign w_drained = !r_inflight && ((w_count - {1'b0, w_pop}) == 2'd0);

  fifo2 #(.W(DATA_W + 2)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_din   ({r_tag_win, r_tag_ch, rd_data}),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_count (w_count)
  );

  assign out_data     = out_valid ? w_dout[DATA_W-1:0] : '0;
  assign out_ch_last  = out_valid && w_dout[DATA_W];
  assign out_win_last = out_valid && w_dout[DATA_W+1];
  assign busy         = (r_state == RUN) || (r_state == DRAIN);
  assign done         = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_e        <= 2'd0;
      r_wc       <= '0;
      r_wr       <= '0;
      r_ch       <= '0;
      r_inflight <= 1'b0;
      r_tag_win  <= 1'b0;
      r_tag_ch   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= rd_en;
      if (rd_en) begin
        r_tag_win <= w_last_e;
        r_tag_ch  <= w_ch_last;
      end
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= RUN;
            r_done  <= 1'b0;
            r_e     <= 2'd0;
            r_wc    <= '0;
            r_wr    <= '0;
            r_ch    <= '0;
          end
        end
        RUN: begin
          if (rd_en) begin
            r_e <= r_e + 2'd1;
            if (w_last_e) begin
              r_wc <= w_wc_max ? '0 : r_wc + WB'(1);
              if (w_wc_max) begin
                r_wr <= w_wr_max ? '0 : r_wr + WB'(1);
                if (w_wr_max) r_ch <= w_ch_max ? '0 : r_ch + CH_W'(1);
              end
            end
            if (w_final) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_drained) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/conv2_mem_read.md
# conv2_mem_read

Read-side addresser/streamer for the Convolution 2 output memory: once the write side has filled 3 channels of 8x8 results, this block walks the memory in 2x2 pooling-window order and streams the words to the Pool 2 stage over a valid/ready interface. It sits between the conv2 output RAM (1-cycle synchronous read) and the pooling datapath. It absorbs downstream back-pressure without losing in-flight reads and reports completion with a sticky `done`.

## Interface
- `DATA_W`, default 16: memory/output word width.
- `IMG_W`, default 8: image side; must be a power of 2, ≥2.
- `CHANNELS`, default 3: number of 8x8 planes.

Ports (reset is `reset`, asynchronous, active-high; clock is `clk`):
- `clk`  in  1  clock.
- `reset`  in  1  async active-high reset.
- `start`  in  1  single-cycle request to begin a pass; ignored unless in IDLE or DONE.
- `rd_en`  out  1  memory read strobe.
- `addr`  out  log2(IMG_W²) (6)  pixel address within a plane.
- `ch`  out  log2(CHANNELS) (2)  plane select.
- `rd_data`  in  DATA_W  memory data, valid exactly 1 cycle after `rd_en`.
- `out_data`  out  DATA_W  streamed word.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts; transfer = `out_valid & out_ready`.
- `out_win_last`  out  1  qualifies `out_data` as 4th word of a 2x2 window.
- `out_ch_last`  out  1  qualifies `out_data` as last word of a channel.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  sticky pass-complete flag.

## Operation
- States:
  - IDLE: reset state.
  - RUN: issuing reads.
  - DRAIN: all reads issued; flushing buffered words.
  - DONE: `done`=1.
- Transitions:
  - IDLE/DONE + `start` → RUN. Clears `done` and all counters.
  - RUN → DRAIN on the edge that issues the final read (index CHANNELS·IMG_W²−1).
  - DRAIN → DONE when the FIFO is empty, no read is in flight, and no pop is pending.
  - `start` in RUN/DRAIN has no effect.
- Address order, per read index:
  - Nested counters: `ch`, then window row `wr` (0..IMG_W/2−1), then window col `wc`, then element `e` (0..3, `dy`=e[1], `dx`=e[0]), with `ch` outermost.
  - `addr` = (2·wr+dy)·IMG_W + 2·wc+dx.
  - Window 0 of ch 0: 0,1,8,9. Window 1: 2,3,10,11. Window (wr1,wc0): 16,17,24,25. Last window: 54,55,62,63.
  - Counters wrap: `e` 3→0 increments `wc`; `wc` max→0 increments `wr`; `wr` max→0 increments `ch`.
- Buffering:
  - 2-entry FIFO holds returned data plus its `win_last`/`ch_last` tags.
  - A read is issued in a cycle only when (fifo_count + inflight − pop_this_cycle) < 2. This guarantees no overflow under any stall pattern.
  - `rd_data` is pushed unconditionally in the cycle after `rd_en`.
- Tags are computed at issue time, delayed with the read, and stored with the data:
  - `win_last` = (e==3).
  - `ch_last` = (e==3 & wc,wr max).
- Reset mid-operation: all state returns to IDLE immediately; FIFO is emptied; the in-flight read is discarded.
- Reset values: `rd_en`=0, `addr`=0, `ch`=0, `out_valid`=0, `out_data`=0, `out_win_last`=0, `out_ch_last`=0, `busy`=0, `done`=0.

## Timing
- `start` sampled at edge E0. `rd_en` with addr 0/ch 0 is asserted in the following cycle (C1).
- `rd_data` arrives in C2 and is written to the FIFO at the end of C2. `out_valid` rises in C3.
- Latency from start to first output: 3 cycles.
- Throughput: with `out_ready` held high, one word per cycle. 192 words are delivered in C3..C194, and `done`=1 from C195.
- `out_valid` and `out_data` are registered from FIFO state.
- Once `out_valid` is asserted it stays asserted, and `out_data` stays stable, until accepted.
- While `out_ready`=0 and the FIFO is full, `rd_en` stays low and `addr`/`ch` hold.
- Simultaneous push and pop with count=2 is legal. The issue rule above prevents a push into a full FIFO without a pop.
- `start` in the same cycle as the DRAIN→DONE edge is ignored. It is honored from DONE on any later cycle.

## Structure
- Shared package `conv_pkg`:
  - constants `IMG_W2`=8, `CONV2_CH`=3, `CONV_DATA_W`=16.
  - `typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rd_state_t`.
- One sub-module `fifo2`: 2-entry synchronous FIFO with payload width DATA_W+2, push/pop, count output, async reset.
- The address generator and FSM live in the top module.

## Test plan
- Free-flow pass: `start` pulse with `out_ready`=1.
  - First `out_valid` in C3.
  - Stream is 0,1,8,9,2,3,10,11,…,54,55,62,63, repeated for ch 0..2, with the memory model returning ch·64+addr.
  - 192 transfers with no gaps; `done` in C195.
- Tags: `out_win_last` on every 4th transfer (48 total); `out_ch_last` on transfers 64, 128, 192 only.
- Back-pressure: random `out_ready`, 30% duty.
  - Output sequence is identical to the free-flow pass; no drops or duplicates.
  - `out_data` is stable while `out_valid & !out_ready`.
  - `rd_en` is never high when count+inflight=2 without a pop.
- Hold stall: `out_ready`=0 from C3 for 20 cycles.
  - The FIFO holds addr 0 and addr 1 data.
  - `rd_en` stays low and `addr` stays 8.
  - Streaming resumes with addr 0 when ready returns.
- Reset mid-run: assert `reset` at transfer 70.
  - All outputs are 0 and the state is IDLE.
  - A new `start` replays from ch 0 addr 0.
- Spurious/restart `start`:
  - `start` during RUN leaves the sequence unchanged.
  - `start` in DONE clears `done` and runs a full second pass with identical output.
